prefix_carry_pipe: RTL and testbench
====================================

PREFIX_CARRY_PIPE -- requirements
Module: prefix_carry_pipe

Interface
REQ-001 Parameter WIDTH, default 7, SHALL set the operand bit width and match the preprocessing stage width.
REQ-002 Parameter LEVELS, default 3, SHALL equal ceil(log2(WIDTH)) and set the number of prefix levels and pipeline registers.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  SHALL mark the input bundle as valid.
REQ-006 in_ready  output  1  SHALL show that the block accepts the input bundle this cycle.
REQ-007 g, p, h  input  WIDTH each  SHALL carry the generate, propagate (OR) and half-sum vectors of the unmodified path.
REQ-008 g_prim, p_prim, h_prim  input  WIDTH each  SHALL carry the same three vectors for the k-corrected (primed) path.
REQ-009 out_valid  output  1  SHALL mark the output bundle as valid.
REQ-010 out_ready  input  1  SHALL show that the consumer accepts the output bundle this cycle.
REQ-011 c, c_prim  output  WIDTH each  SHALL give the group carries: c[i] = G[i:0], with no carry-in.
REQ-012 h_out, h_prim_out  output  WIDTH each  SHALL give h and h_prim, delayed to stay aligned with c and c_prim.
REQ-013 sel  output  1  SHALL equal c_prim[WIDTH-1], the carry-out of the primed path, for the sum-select stage.

Function
REQ-014 The block SHALL apply the prefix operator (gl,pl) o (gr,pr) = (gl | pl&gr, pl&pr) to both paths independently.
REQ-015 It SHALL use the Kogge-Stone layout: level L combines bit i with bit i-2^(L-1) when i >= 2^(L-1), and passes the bit through otherwise.
REQ-016 One pipeline register SHALL follow each prefix level, giving LEVELS stages.
REQ-017 Latency SHALL be exactly LEVELS cycles (3 at default) from an accepted input to its out_valid, with no stall.
REQ-018 Each stage SHALL hold a valid bit.
REQ-019 The pipeline SHALL advance as a whole when en = !out_valid | out_ready.
REQ-020 in_ready SHALL equal en, computed combinationally; there is no internal skid buffer.
REQ-021 Data SHALL be captured only when in_valid & in_ready.
REQ-022 When in_valid = 0 and en = 1, a bubble (valid = 0) SHALL enter stage 1.
REQ-023 When out_valid = 1 and out_ready = 0, all stage registers and outputs SHALL hold their values unchanged.
REQ-024 Outputs SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-025 Throughput SHALL be one bundle per cycle while out_ready = 1.
REQ-026 Bundles SHALL leave in the order they were accepted; no bundle is dropped or duplicated.
REQ-027 Data registers MAY update without reset when their valid bit is 0; data is only meaningful when out_valid = 1.
REQ-028 The block SHALL have no state machine beyond the valid-bit shift register.
REQ-029 No output SHALL depend combinationally on in_* except in_ready, which depends on out_ready.

Reset
REQ-030 When rst_n = 0 at a clock edge, all stage valid bits SHALL clear, so out_valid = 0 on the next cycle.
REQ-031 During reset, in_ready SHALL read 1 (all stages empty), but no input SHALL be captured while rst_n = 0.
REQ-032 c, c_prim, h_out, h_prim_out and sel SHALL reset to 0.
REQ-033 A reset asserted mid-stream SHALL discard all in-flight bundles; after release, the first accepted bundle appears LEVELS cycles later.

Structure
REQ-034 WIDTH, LEVELS, the bundle struct {g, p, h} and the prefix-pair typedef SHALL live in the shared package adder_pkg, also used by the preprocessing stage.
REQ-035 The prefix operator SHALL be a sub-module named prefix_cell (inputs gl, pl, gr, pr; outputs g, p), instantiated per bit, per level and per path.

Verification
REQ-036 g=7'b0000001, p=7'b1111111 for both paths, out_ready=1 -> c=c_prim=7'b1111111, sel=1, out_valid exactly 3 cycles after acceptance.
REQ-037 g=7'b0000100, p=7'b0001100; g_prim=0, p_prim=7'b1111111 -> c=7'b0001100, c_prim=7'b0000000, sel=0.
REQ-038 Stream of 8 back-to-back bundles with out_ready=1 -> 8 consecutive out_valid cycles, outputs in order, h_out/h_prim_out aligned with their inputs.
REQ-039 Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, outputs frozen; on release, no loss or duplication and in_ready returns the same cycle.
REQ-040 Pulse rst_n=0 for one cycle with 3 bundles in flight -> out_valid=0 and all outputs 0 next cycle; the next accepted bundle emerges after 3 cycles.
REQ-041 Random g/p vectors (g subset of p), 10k bundles with random in_valid/out_ready -> c and c_prim match a ripple-carry reference model bit-for-bit.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared adder types: operand width, prefix depth and the {g, p, h} bundle
// handed from the preprocessing stage to the carry network.
package adder_pkg;

  localparam int WIDTH  = 7;
  localparam int LEVELS = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] h;
  } bundle_t;

  typedef struct packed {
    logic g;
    logic p;
  } prefix_pair_t;

endpackage

// File: rtl/prefix_cell.sv
// Prefix operator (gl,pl) o (gr,pr) = (gl | pl&gr, pl&pr); the left operand
// is the more significant group.
module prefix_cell (
  input  logic gl,
  input  logic pl,
  input  logic gr,
  input  logic pr,
  output logic g,
  output logic p
);

  assign g = gl | (pl & gr);
  assign p = pl & pr;

endmodule

// File: rtl/prefix_carry_pipe.sv
// Pipelined Kogge-Stone carry network for the plain and k-corrected paths,
// one register per prefix level, with a valid/ready handshake on both ends.
module prefix_carry_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = adder_pkg::WIDTH,
  parameter int LEVELS = adder_pkg::LEVELS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] h,
  input  logic [WIDTH-1:0] g_prim,
  input  logic [WIDTH-1:0] p_prim,
  input  logic [WIDTH-1:0] h_prim,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_prim,
  output logic [WIDTH-1:0] h_out,
  output logic [WIDTH-1:0] h_prim_out,
  output logic             sel
);

  localparam int PATHS = 2;

  bundle_t          in_bundle [PATHS];
  bundle_t          stage_reg [LEVELS][PATHS];
  logic [WIDTH-1:0] g_next    [LEVELS][PATHS];
  logic [WIDTH-1:0] p_next    [LEVELS][PATHS];
  logic [WIDTH-1:0] h_next    [LEVELS][PATHS];
  logic [LEVELS-1:0] vld_reg;
  logic             en;

  assign out_valid = vld_reg[LEVELS-1];
  assign en        = !out_valid || out_ready;
  // All stages are being emptied while in reset, so advertise space even if
  // the previous contents were stalled; nothing is captured until release.
  assign in_ready  = en || !rst_n;

  assign in_bundle[0] = '{g: g,      p: p,      h: h};
  assign in_bundle[1] = '{g: g_prim, p: p_prim, h: h_prim};

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
    localparam int SPAN = 1 << lv;
    for (genvar pa = 0; pa < PATHS; pa++) begin : g_path
      bundle_t src;
      if (lv == 0) begin : g_first
        assign src = in_bundle[pa];
      end else begin : g_rest
        assign src = stage_reg[lv-1][pa];
      end

      assign h_next[lv][pa] = src.h;

      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi >= SPAN) begin : g_cell
          prefix_cell u_cell (
            .gl (src.g[gi]),
            .pl (src.p[gi]),
            .gr (src.g[gi-SPAN]),
            .pr (src.p[gi-SPAN]),
            .g  (g_next[lv][pa][gi]),
            .p  (p_next[lv][pa][gi])
          );
        end else begin : g_pass
          assign g_next[lv][pa][gi] = src.g[gi];
          assign p_next[lv][pa][gi] = src.p[gi];
        end
      end
    end
  end

  // The whole pipe moves in lockstep; bubbles carry don't-care data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_reg <= '0;
      for (int lv = 0; lv < LEVELS; lv++) begin
        for (int pa = 0; pa < PATHS; pa++) begin
          stage_reg[lv][pa] <= '0;
        end
      end
    end else if (en) begin
      vld_reg <= (vld_reg << 1) | LEVELS'(in_valid);
      for (int lv = 0; lv < LEVELS; lv++) begin
        for (int pa = 0; pa < PATHS; pa++) begin
          stage_reg[lv][pa] <= '{g: g_next[lv][pa], p: p_next[lv][pa], h: h_next[lv][pa]};
        end
      end
    end
  end

  assign c          = stage_reg[LEVELS-1][0].g;
  assign c_prim     = stage_reg[LEVELS-1][1].g;
  assign h_out      = stage_reg[LEVELS-1][0].h;
  assign h_prim_out = stage_reg[LEVELS-1][1].h;
  assign sel        = c_prim[WIDTH-1];

endmodule

// File: tb/tb_prefix_carry_pipe.sv
// Self-checking bench for prefix_carry_pipe: hand-computed vector table,
// stream/stall/reset sequences and a randomized run against a ripple model.
module tb_prefix_carry_pipe;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, sel;
  logic [W-1:0] g, p, h, g_prim, p_prim, h_prim;
  logic [W-1:0] c, c_prim, h_out, h_prim_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prefix_carry_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .g          (g),
    .p          (p),
    .h          (h),
    .g_prim     (g_prim),
    .p_prim     (p_prim),
    .h_prim     (h_prim),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .c          (c),
    .c_prim     (c_prim),
    .h_out      (h_out),
    .h_prim_out (h_prim_out),
    .sel        (sel)
  );

  typedef struct packed {
    logic [W-1:0] c;
    logic [W-1:0] cp;
    logic [W-1:0] h;
    logic [W-1:0] hp;
    logic         sel;
  } exp_t;

  typedef struct {
    logic [W-1:0] g, p, h, gp, pp, hp, ec, ecp;
    logic         esel;
  } vec_rec_t;

  exp_t     sb_q[$];
  vec_rec_t tbl[6];

  function automatic logic [W-1:0] ripple(input logic [W-1:0] gv, input logic [W-1:0] pv);
    logic         cy = 1'b0;
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      cy   = gv[i] | (pv[i] & cy);
      r[i] = cy;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: handshakes are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pop: unexpected output c=%b c_prim=%b h_out=%b, scoreboard empty",
                   c, c_prim, h_out);
        end else begin
          e = sb_q.pop_front();
          if ({c, c_prim, h_out, h_prim_out, sel} !== e) begin
            n_fail++;
            $display("FAIL sb_data: got c=%b cp=%b h=%b hp=%b sel=%b expected c=%b cp=%b h=%b hp=%b sel=%b",
                     c, c_prim, h_out, h_prim_out, sel, e.c, e.cp, e.h, e.hp, e.sel);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.c   = ripple(g, p);
        e.cp  = ripple(g_prim, p_prim);
        e.h   = h;
        e.hp  = h_prim;
        e.sel = e.cp[W-1];
        sb_q.push_back(e);
      end
    end
  end

  task automatic rand_bundle();
    p      = W'($urandom);
    g      = W'($urandom) & p;
    h      = W'($urandom);
    p_prim = W'($urandom);
    g_prim = W'($urandom) & p_prim;
    h_prim = W'($urandom);
  endtask

  task automatic send();
    int   k = 0;
    logic acc;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 50);
    chk("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  // Counts the accepting edge as cycle 1.
  task automatic measure_lat(output int lat);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid) && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int           lat, ov_total, run, best, accepted, cyc;
    logic         acc;
    logic [31:0]  snap;

    tbl[0] = '{g:7'b0000001, p:7'b1111111, h:7'b1010101, gp:7'b0000001, pp:7'b1111111, hp:7'b0101010,
               ec:7'b1111111, ecp:7'b1111111, esel:1'b1};
    tbl[1] = '{g:7'b0000100, p:7'b0001100, h:7'b0011001, gp:7'b0000000, pp:7'b1111111, hp:7'b1100110,
               ec:7'b0001100, ecp:7'b0000000, esel:1'b0};
    tbl[2] = '{g:7'b0000000, p:7'b0000000, h:7'b1111111, gp:7'b0000000, pp:7'b0000000, hp:7'b0000000,
               ec:7'b0000000, ecp:7'b0000000, esel:1'b0};
    tbl[3] = '{g:7'b1000000, p:7'b1000000, h:7'b0000001, gp:7'b0100000, pp:7'b1100000, hp:7'b1000000,
               ec:7'b1000000, ecp:7'b1100000, esel:1'b1};
    tbl[4] = '{g:7'b0001010, p:7'b0111110, h:7'b0110110, gp:7'b1111111, pp:7'b1111111, hp:7'b1001001,
               ec:7'b0111110, ecp:7'b1111111, esel:1'b1};
    tbl[5] = '{g:7'b0100001, p:7'b0110011, h:7'b1110000, gp:7'b0000000, pp:7'b0000000, hp:7'b0001111,
               ec:7'b0100011, ecp:7'b0000000, esel:1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    g = '0; p = '0; h = '0; g_prim = '0; p_prim = '0; h_prim = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_outputs",   32'({c, c_prim, h_out, h_prim_out, sel}), 32'd0);
    rst_n = 1'b1;

    // Hand-computed vectors, one at a time
    for (int i = 0; i < 6; i++) begin
      g = tbl[i].g; p = tbl[i].p; h = tbl[i].h;
      g_prim = tbl[i].gp; p_prim = tbl[i].pp; h_prim = tbl[i].hp;
      send();
      measure_lat(lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_c", i),      32'(c),          32'(tbl[i].ec));
      chk($sformatf("vec%0d_c_prim", i), 32'(c_prim),     32'(tbl[i].ecp));
      chk($sformatf("vec%0d_sel", i),    32'(sel),        32'(tbl[i].esel));
      chk($sformatf("vec%0d_h_out", i),  32'(h_out),      32'(tbl[i].h));
      chk($sformatf("vec%0d_hp_out", i), 32'(h_prim_out), 32'(tbl[i].hp));
      @(posedge clk);
      #1;
    end

    // Eight back-to-back bundles must come out as eight consecutive valids
    ov_total = 0; run = 0; best = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 8) begin
        rand_bundle();
        send();
      end else begin
        @(posedge clk);
        #1;
      end
      if (out_valid) begin
        ov_total++;
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    chk("stream_total", 32'(ov_total), 32'd8);
    chk("stream_run",   32'(best),     32'd8);
    drain();

    // Fill the pipe with the consumer stalled, then hold for five cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_bundle();
      send();
    end
    chk("stall_full_valid", 32'(out_valid), 32'd1);
    rand_bundle();
    in_valid = 1'b1;
    #1;
    snap = 32'({c, c_prim, h_out, h_prim_out, sel});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_in_ready", i),  32'(in_ready),  32'd0);
      chk($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_frozen", i),    32'({c, c_prim, h_out, h_prim_out, sel}), snap);
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // One-cycle reset with bundles in flight; an input offered during reset must be ignored
    for (int i = 0; i < 3; i++) begin
      rand_bundle();
      send();
    end
    rand_bundle();
    in_valid = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs",   32'({c, c_prim, h_out, h_prim_out, sel}), 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    rand_bundle();
    send();
    measure_lat(lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    drain();

    // Randomized traffic, checked against the ripple model by the scoreboard
    accepted = 0; cyc = 0; acc = 1'b0; in_valid = 1'b0;
    while (accepted < 10000 && cyc < 60000) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        rand_bundle();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) accepted++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("random_accepted", 32'(accepted), 32'd10000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
